// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous instruction queue; flush wins over push and pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [63:0]               push_data,
    output logic [63:0]               head,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // Pop only real entries; push only when a slot exists (or one is freed now).
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != CW'(QDEPTH)) || pop_ok);
    end

    // Pointer and occupancy bookkeeping; pointers wrap as QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are only meaningful while count covers them.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, credit-limited imem handshake, decode queue.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          drop;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          push;
    logic          pop;
    logic [CW-1:0] free;
    logic [CW-1:0] count_next;
    logic [CW-1:0] free_after;
    logic [31:0]   target_pc;
    entry_t        head_entry;

    // Credit: slots not already used by queued entries or the request in flight.
    always_comb begin
        target_pc  = align_pc(redirect_pc);
        pop        = if_valid && if_ready;
        push       = (state == S_WAIT) && imem_rvalid && !drop && !redirect_valid;
        free       = CW'(QDEPTH) - count - CW'(state == S_WAIT);
        count_next = count + CW'(push) - CW'(pop);
        free_after = CW'(QDEPTH) - count_next;
    end

    // Fetch FSM with PC register and registered request output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= target_pc;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end else if (free != '0) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= redirect_valid ? target_pc : fetch_pc + PC_STEP;
                        drop     <= redirect_valid;
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end else if (redirect_valid) begin
                        fetch_pc <= target_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) fetch_pc <= target_pc;
                    if (imem_rvalid) begin
                        // A response coinciding with a redirect is consumed and discarded here.
                        drop <= 1'b0;
                        if (redirect_valid || free_after != '0) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    ifetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({req_pc, imem_rdata}),
        .head      (head),
        .count     (count)
    );

    // Head presentation; empty queue shows zeros.
    always_comb begin
        head_entry  = head;
        if_valid    = (count != '0);
        if_pc       = if_valid ? head_entry.pc : '0;
        if_instr    = if_valid ? head_entry.instr : '0;
        if_pc_plus4 = if_pc + PC_STEP;
    end

    assign imem_addr = fetch_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory model returns the address as data.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    int          total  = 0;
    int          passed = 0;
    bit          gnt_en = 1'b0;
    int          lat    = 1;
    bit          pend   = 1'b0;
    int          pcnt   = 0;
    logic [31:0] paddr  = '0;

    typedef struct {
        bit          rst_before;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory model, stepped once per cycle at the falling edge.
    task automatic mem_step();
        imem_rvalid = 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr;
                pend        = 1'b0;
            end else begin
                pcnt--;
            end
        end
        imem_gnt = imem_req && gnt_en && !pend;
        if (imem_gnt) begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = imem_addr;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mem_step();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        cyc();
        cyc();
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc",    if_pc, 32'h0);
        rst = 1'b0;
    endtask

    // Wait a bounded number of cycles for a head entry and check its PC/instruction.
    task automatic expect_head(input string nm, input logic [31:0] pc, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc();
            if (if_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: got no if_valid expected head pc %h", nm, pc);
        end else begin
            chk({nm, "_pc"}, if_pc, pc);
            chk({nm, "_instr"}, if_instr, pc);
        end
    endtask

    initial begin
        // Zero-wait stream, decode always ready.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b0, 32'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        // Decode stalled: two entries fill the queue, then requests stop until drained.
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h04, 1'b0, 32'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        for (int i = 12; i < 19; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h04};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h00};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};

        lat    = 1;
        gnt_en = 1'b1;
        for (int i = 0; i < 23; i++) begin
            if (vecs[i].rst_before) do_reset();
            if_ready = vecs[i].ready;
            cyc();
            chk($sformatf("vec%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("vec%0d_addr", i),  imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i),    if_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_pc);
                chk($sformatf("vec%0d_pc4", i),   if_pc_plus4, vecs[i].exp_pc + 32'd4);
            end
        end

        // Grant withheld: address must hold, nothing pushed.
        do_reset();
        lat = 1; gnt_en = 1'b0; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall%0d_req", i),   {31'b0, imem_req}, 32'h1);
            chk($sformatf("stall%0d_addr", i),  imem_addr, 32'h10);
            chk($sformatf("stall%0d_valid", i), {31'b0, if_valid}, 32'h0);
            if (i == 3) gnt_en = 1'b1;
            cyc();
        end
        chk("stall_gnt_addr", imem_addr, 32'h10);
        cyc();
        chk("stall_wait_req", {31'b0, imem_req}, 32'h0);
        chk("stall_wait_addr", imem_addr, 32'h14);
        cyc();
        chk("stall_head_valid", {31'b0, if_valid}, 32'h1);
        chk("stall_head_pc", if_pc, 32'h10);

        // Redirect while waiting on 0x20: response dropped, refetch from 0x400.
        do_reset();
        lat = 3; gnt_en = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc();
        redirect_valid = 1'b0;
        chk("rdw_req_addr", imem_addr, 32'h20);
        cyc();
        chk("rdw_wait_req", {31'b0, imem_req}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        cyc();
        redirect_valid = 1'b0;
        chk("rdw_addr", imem_addr, 32'h400);
        chk("rdw_valid0", {31'b0, if_valid}, 32'h0);
        cyc();
        chk("rdw_valid1", {31'b0, if_valid}, 32'h0);
        cyc();
        chk("rdw_drop_valid", {31'b0, if_valid}, 32'h0);
        chk("rdw_new_req", {31'b0, imem_req}, 32'h1);
        chk("rdw_new_addr", imem_addr, 32'h400);
        expect_head("rdw_head", 32'h400, 8);

        // Redirect to 0x103 coinciding with the response that would fill the queue.
        do_reset();
        lat = 1; gnt_en = 1'b1; if_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("rdv_pre_pc", if_pc, 32'h0);
        chk("rdv_pre_rvalid", {31'b0, imem_rvalid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cyc();
        redirect_valid = 1'b0;
        chk("rdv_flush_valid", {31'b0, if_valid}, 32'h0);
        chk("rdv_req", {31'b0, imem_req}, 32'h1);
        chk("rdv_addr", imem_addr, 32'h100);
        if_ready = 1'b1;
        expect_head("rdv_head", 32'h100, 6);

        // PC wrap at the top of the address space.
        do_reset();
        lat = 1; gnt_en = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", imem_addr, 32'h0);
        cyc();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0);

        // Reset during S_WAIT with the response arriving after reset.
        do_reset();
        lat = 2; gnt_en = 1'b1; if_ready = 1'b1;
        cyc();
        chk("mrst_req", {31'b0, imem_req}, 32'h1);
        cyc();
        chk("mrst_wait", {31'b0, imem_req}, 32'h0);
        rst = 1'b1;
        cyc();
        chk("mrst_out_req", {31'b0, imem_req}, 32'h0);
        chk("mrst_out_addr", imem_addr, 32'h0);
        chk("mrst_out_valid", {31'b0, if_valid}, 32'h0);
        chk("mrst_out_pc", if_pc, 32'h0);
        chk("mrst_out_instr", if_instr, 32'h0);
        rst = 1'b0;
        cyc();
        chk("mrst_late_valid", {31'b0, if_valid}, 32'h0);
        chk("mrst_restart_req", {31'b0, imem_req}, 32'h1);
        chk("mrst_restart_addr", imem_addr, 32'h0);
        expect_head("mrst_head", 32'h0, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
